sprite_cfg_ctrl: RTL and testbench

- Command controller between the SPI byte receiver and the sprite/SVGA pixel datapath.
- Decodes SPI command bytes into shadow configuration registers: sprite position and palette.
- Streams bitmap bytes into the sprite memory write port.
- Copies shadow to active registers only on a frame boundary, so the visible frame never tears.

---
 rtl/sprite_cfg_pkg.sv | 35 +++
 rtl/sprite_cfg_ctrl.sv | 144 ++++++++++++++
 tb/tb_sprite_cfg_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_cfg_pkg.sv
// Shared types and constants for the sprite configuration controller.
package sprite_cfg_pkg;

  localparam logic [7:0] OP_SET_POS     = 8'h01;
  localparam logic [7:0] OP_SET_COLORS  = 8'h02;
  localparam logic [7:0] OP_WRITE_BMP   = 8'h03;
  localparam logic [7:0] OP_COMMIT      = 8'h04;
  localparam logic [7:0] OP_READ_STATUS = 8'h05;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    STREAM  = 2'd2,
    IGNORE  = 2'd3
  } cfg_state_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [5:0] bg;
    logic [5:0] c1;
    logic [5:0] c2;
    logic [5:0] c3;
  } sprite_cfg_t;

  localparam sprite_cfg_t CFG_RESET = '{
    x:  10'd0,
    y:  10'd0,
    bg: 6'h00,
    c1: 6'h30,
    c2: 6'h0C,
    c3: 6'h03
  };

endpackage

// File: rtl/sprite_cfg_ctrl.sv
// SPI command decoder: stages sprite position/palette into shadow registers,
// streams bitmap bytes, and commits shadow to active on a frame boundary.
module sprite_cfg_ctrl
  import sprite_cfg_pkg::*;
#(
  parameter int unsigned SPRITE_BYTES = 36,
  parameter int unsigned ADDR_W       = $clog2(SPRITE_BYTES)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cs_active,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic [7:0]        tx_data,
  input  logic              next_frame,
  output logic [9:0]        sprite_x,
  output logic [9:0]        sprite_y,
  output logic [5:0]        color_bg,
  output logic [5:0]        color_1,
  output logic [5:0]        color_2,
  output logic [5:0]        color_3,
  output logic              bmp_we,
  output logic [ADDR_W-1:0] bmp_addr,
  output logic [7:0]        bmp_wdata,
  output logic              update_pending
);

  cfg_state_t        state;
  sprite_cfg_t       shadow_q;
  sprite_cfg_t       active_q;
  sprite_cfg_t       shadow_upd_c;
  logic              is_pos_q;
  logic [1:0]        byte_cnt;
  logic [5:0]        stg0;
  logic [7:0]        stg1;
  logic [5:0]        stg2;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] wr_ptr_inc_c;
  logic [6:0]        frame_cnt;

  assign wr_ptr_inc_c = (wr_ptr == ADDR_W'(SPRITE_BYTES - 1)) ? '0 : wr_ptr + ADDR_W'(1);

  // Shadow image after the 4th payload byte; staged bytes 0..2 plus the live byte.
  always_comb begin
    shadow_upd_c = shadow_q;
    if (is_pos_q) begin
      shadow_upd_c.x = {stg0[1:0], stg1};
      shadow_upd_c.y = {stg2[1:0], rx_data};
    end else begin
      shadow_upd_c.bg = stg0;
      shadow_upd_c.c1 = stg1[5:0];
      shadow_upd_c.c2 = stg2;
      shadow_upd_c.c3 = rx_data[5:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      shadow_q       <= CFG_RESET;
      active_q       <= CFG_RESET;
      is_pos_q       <= 1'b0;
      byte_cnt       <= 2'd0;
      stg0           <= 6'd0;
      stg1           <= 8'd0;
      stg2           <= 6'd0;
      wr_ptr         <= '0;
      frame_cnt      <= 7'd0;
      tx_data        <= 8'h00;
      bmp_we         <= 1'b0;
      bmp_addr       <= '0;
      bmp_wdata      <= 8'h00;
      update_pending <= 1'b0;
    end else begin
      bmp_we <= 1'b0;

      if (next_frame) frame_cnt <= frame_cnt + 7'd1;

      // Commit uses the pre-edge shadow; a same-cycle COMMIT below re-arms pending.
      if (next_frame && update_pending) begin
        active_q       <= shadow_q;
        update_pending <= 1'b0;
      end

      if (!cs_active) begin
        state   <= IDLE;
        tx_data <= 8'h00;
      end else if (rx_valid) begin
        case (state)
          IDLE: begin
            case (rx_data)
              OP_SET_POS, OP_SET_COLORS: begin
                state    <= PAYLOAD;
                byte_cnt <= 2'd0;
                is_pos_q <= (rx_data == OP_SET_POS);
              end
              OP_WRITE_BMP: begin
                state    <= STREAM;
                wr_ptr   <= '0;
                bmp_addr <= '0;
              end
              OP_COMMIT: begin
                update_pending <= 1'b1;
                state          <= IGNORE;
              end
              OP_READ_STATUS: begin
                tx_data <= {update_pending, frame_cnt};
                state   <= IGNORE;
              end
              default: state <= IGNORE;
            endcase
          end
          PAYLOAD: begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0:    stg0 <= rx_data[5:0];
              2'd1:    stg1 <= rx_data;
              2'd2:    stg2 <= rx_data[5:0];
              default: begin
                shadow_q <= shadow_upd_c;
                state    <= IGNORE;
              end
            endcase
          end
          STREAM: begin
            bmp_we    <= 1'b1;
            bmp_wdata <= rx_data;
            bmp_addr  <= wr_ptr;
            wr_ptr    <= wr_ptr_inc_c;
          end
          default: ;
        endcase
      end
    end
  end

  assign sprite_x = active_q.x;
  assign sprite_y = active_q.y;
  assign color_bg = active_q.bg;
  assign color_1  = active_q.c1;
  assign color_2  = active_q.c2;
  assign color_3  = active_q.c3;

endmodule

// File: tb/tb_sprite_cfg_ctrl.sv
// Bench for sprite_cfg_ctrl: directed scenarios plus random SPI frames,
// compared against a frame-level model of the command protocol.
module tb_sprite_cfg_ctrl;

  localparam int unsigned SPRITE_BYTES = 36;
  localparam int unsigned ADDR_W       = 6;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              cs_active;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic [7:0]        tx_data;
  logic              next_frame;
  logic [9:0]        sprite_x;
  logic [9:0]        sprite_y;
  logic [5:0]        color_bg;
  logic [5:0]        color_1;
  logic [5:0]        color_2;
  logic [5:0]        color_3;
  logic              bmp_we;
  logic [ADDR_W-1:0] bmp_addr;
  logic [7:0]        bmp_wdata;
  logic              update_pending;

  sprite_cfg_ctrl #(.SPRITE_BYTES(SPRITE_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .cs_active(cs_active), .rx_valid(rx_valid),
    .rx_data(rx_data), .tx_data(tx_data), .next_frame(next_frame),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .color_bg(color_bg),
    .color_1(color_1), .color_2(color_2), .color_3(color_3),
    .bmp_we(bmp_we), .bmp_addr(bmp_addr), .bmp_wdata(bmp_wdata),
    .update_pending(update_pending)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int we_cnt = 0;

  // Model: index 0..5 = x, y, bg, c1, c2, c3; m_q holds bytes of the open CS frame.
  logic [9:0] m_sh[6];
  logic [9:0] m_act[6];
  logic       m_pend;
  logic [6:0] m_fcnt;
  logic [7:0] m_tx;
  logic [7:0] m_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sh   = '{10'd0, 10'd0, 10'h00, 10'h30, 10'h0C, 10'h03};
    m_act  = m_sh;
    m_pend = 1'b0;
    m_fcnt = 7'd0;
    m_tx   = 8'h00;
    m_q.delete();
  endtask

  task automatic model_step(input logic cs, input logic vld, input logic [7:0] b, input logic nf,
                            output logic exp_we, output int exp_addr);
    logic new_pend;
    int   n;
    exp_we   = 1'b0;
    exp_addr = 0;
    new_pend = m_pend;
    if (nf && m_pend) begin
      m_act    = m_sh;
      new_pend = 1'b0;
    end
    if (!cs) begin
      m_q.delete();
      m_tx = 8'h00;
    end else if (vld) begin
      m_q.push_back(b);
      n = m_q.size();
      if (n == 1) begin
        if (b == 8'h04) new_pend = 1'b1;
        if (b == 8'h05) m_tx = {m_pend, m_fcnt};
      end else if (m_q[0] == 8'h01 && n == 5) begin
        m_sh[0] = {m_q[1][1:0], m_q[2]};
        m_sh[1] = {m_q[3][1:0], m_q[4]};
      end else if (m_q[0] == 8'h02 && n == 5) begin
        m_sh[2] = 10'(m_q[1][5:0]);
        m_sh[3] = 10'(m_q[2][5:0]);
        m_sh[4] = 10'(m_q[3][5:0]);
        m_sh[5] = 10'(m_q[4][5:0]);
      end else if (m_q[0] == 8'h03) begin
        exp_we   = 1'b1;
        exp_addr = (n - 2) % SPRITE_BYTES;
      end
    end
    m_pend = new_pend;
    if (nf) m_fcnt = m_fcnt + 7'd1;
  endtask

  task automatic check_outputs(input logic exp_we, input int exp_addr, input logic [7:0] exp_data);
    chk("sprite_x", 32'(sprite_x), 32'(m_act[0]));
    chk("sprite_y", 32'(sprite_y), 32'(m_act[1]));
    chk("color_bg", 32'(color_bg), 32'(m_act[2]));
    chk("color_1",  32'(color_1),  32'(m_act[3]));
    chk("color_2",  32'(color_2),  32'(m_act[4]));
    chk("color_3",  32'(color_3),  32'(m_act[5]));
    chk("pending",  32'(update_pending), 32'(m_pend));
    chk("tx_data",  32'(tx_data),  32'(m_tx));
    chk("bmp_we",   32'(bmp_we),   32'(exp_we));
    if (exp_we) begin
      chk("bmp_addr",  32'(bmp_addr),  32'(exp_addr));
      chk("bmp_wdata", 32'(bmp_wdata), 32'(exp_data));
    end
  endtask

  // One clock edge: drive at negedge, step the model, check at the next negedge.
  task automatic cycle(input logic cs, input logic vld, input logic [7:0] b, input logic nf);
    logic ew;
    int   ea;
    cs_active  = cs;
    rx_valid   = vld;
    rx_data    = b;
    next_frame = nf;
    model_step(cs, vld, b, nf, ew, ea);
    @(negedge clk);
    rx_valid   = 1'b0;
    next_frame = 1'b0;
    if (bmp_we) we_cnt++;
    check_outputs(ew, ea, b);
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    rx_valid   = 1'b0;
    next_frame = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    chk("rst_bmp_we", 32'(bmp_we), 32'd0);
    chk("rst_bmp_addr", 32'(bmp_addr), 32'd0);
    check_outputs(1'b0, 0, 8'h00);
  endtask

  task automatic send(input logic [7:0] b);
    cycle(1'b1, 1'b1, b, 1'b0);
  endtask

  task automatic cs_open();
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic cs_close();
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic frame_pulse();
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic send_cmd4(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
    cs_open(); send(op); send(a); send(b); send(c); send(d); cs_close();
  endtask

  task automatic send_commit();
    cs_open(); send(8'h04); cs_close();
  endtask

  initial begin
    cs_active = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; next_frame = 1'b0; reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();
    chk("rst_sprite_x", 32'(sprite_x), 32'd0);
    chk("rst_color_1", 32'(color_1), 32'h30);
    chk("rst_pending", 32'(update_pending), 32'd0);

    // Position commit
    send_cmd4(8'h01, 8'h02, 8'h0A, 8'h00, 8'h64);
    send_commit();
    frame_pulse();
    chk("pos_x", 32'(sprite_x), 32'h20A);
    chk("pos_y", 32'(sprite_y), 32'h064);
    chk("pos_pending", 32'(update_pending), 32'd0);

    // Colours are shadowed until a COMMIT
    send_cmd4(8'h02, 8'hFF, 8'h0C, 8'h30, 8'h03);
    frame_pulse();
    frame_pulse();
    chk("nocommit_bg", 32'(color_bg), 32'h00);
    send_commit();
    frame_pulse();
    chk("col_bg", 32'(color_bg), 32'h3F);
    chk("col_c1", 32'(color_1), 32'h0C);

    // Bitmap stream with address wrap
    we_cnt = 0;
    cs_open();
    send(8'h03);
    for (int i = 0; i < 38; i++) send(8'(i));
    chk("bmp_last_addr", 32'(bmp_addr), 32'd1);
    chk("bmp_last_data", 32'(bmp_wdata), 32'h25);
    cs_close();
    chk("bmp_we_count", 32'(we_cnt), 32'd38);

    // Truncated SET_POS is discarded
    cs_open(); send(8'h01); send(8'hAA); send(8'hBB); cs_close();
    send_commit();
    frame_pulse();
    chk("trunc_x", 32'(sprite_x), 32'h20A);
    chk("trunc_y", 32'(sprite_y), 32'h064);

    // READ_STATUS after three frames and a COMMIT
    do_reset();
    frame_pulse(); frame_pulse(); frame_pulse();
    send_commit();
    cs_open(); send(8'h05);
    chk("status_tx", 32'(tx_data), 32'h83);
    cs_close();
    chk("status_tx_clr", 32'(tx_data), 32'h00);

    // COMMIT coinciding with next_frame defers the copy
    frame_pulse();
    send_cmd4(8'h01, 8'h01, 8'h23, 8'h02, 8'h45);
    cs_open();
    cycle(1'b1, 1'b1, 8'h04, 1'b1);
    chk("same_cyc_pending", 32'(update_pending), 32'd1);
    chk("same_cyc_x", 32'(sprite_x), 32'd0);
    cs_close();
    frame_pulse();
    chk("deferred_x", 32'(sprite_x), 32'h123);
    chk("deferred_y", 32'(sprite_y), 32'h245);

    // Reset in the middle of a bitmap stream
    cs_open(); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    do_reset();
    cs_close();

    // rx_valid with chip select low is ignored
    cycle(1'b0, 1'b1, 8'h03, 1'b0);
    cycle(1'b0, 1'b1, 8'h55, 1'b0);

    // Random frames
    for (int it = 0; it < 250; it++) begin
      int r;
      int len;
      logic [7:0] op;
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1:    op = 8'h01;
        2, 3:    op = 8'h02;
        4:       op = 8'h03;
        5, 6:    op = 8'h04;
        7:       op = 8'h05;
        8:       op = 8'(8'h06 + $urandom_range(0, 249));
        default: op = 8'h00;
      endcase
      if (op == 8'h01 || op == 8'h02) len = int'($urandom_range(0, 6));
      else if (op == 8'h03) len = int'($urandom_range(0, 40));
      else len = int'($urandom_range(0, 2));
      cs_open();
      cycle(1'b1, 1'b1, op, $urandom_range(0, 7) == 0);
      for (int k = 0; k < len; k++)
        cycle(1'b1, $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 7) == 0);
      cs_close();
      if ($urandom_range(0, 2) == 0) frame_pulse();
      if ($urandom_range(0, 9) == 0) cycle(1'b0, 1'b1, 8'($urandom), 1'b0);
      if ($urandom_range(0, 39) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
